imem_loader: RTL

//  Writer side of the instruction memory. Receives a program image as a byte stream with

---
 rtl/imem_loader.sv | 147 ++++++++++++++
 1 files changed

// File: rtl/imem_loader.sv
// rtl/imem_loader.sv - byte-stream instruction memory loader with XOR checksum and core hold
module imem_loader #(
    parameter int DEPTH  = 128,
    parameter int ADDR_W = 16
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              start_i,
    input  logic [7:0]        in_data_i,
    input  logic              in_valid_i,
    output logic              in_ready_o,
    output logic              wr_en_o,
    output logic [ADDR_W-1:0] wr_addr_o,
    output logic [15:0]       wr_data_o,
    output logic              cpu_hold_o,
    output logic              done_o,
    output logic              err_o,
    output logic [7:0]        words_loaded_o
);

    typedef enum logic [2:0] {
        S_IDLE, S_HDR, S_LO, S_HI, S_WRITE, S_CSUM, S_DONE, S_ERR
    } state_t;

    localparam logic [8:0] DEPTH_N = 9'(DEPTH);

    state_t            state_q;
    logic [7:0]        n_q;
    logic [7:0]        lo_q;
    logic [7:0]        xor_q;
    logic [ADDR_W-1:0] ptr_q;
    logic [7:0]        words_q;
    logic              in_ready_q;
    logic              wr_en_q;
    logic [ADDR_W-1:0] wr_addr_q;
    logic [15:0]       wr_data_q;
    logic              cpu_hold_q;
    logic              done_q;
    logic              err_q;

    logic              accept_d;
    logic [7:0]        words_d;
    logic [7:0]        xor_d;

    // in_ready_q always mirrors the byte-accepting states, so this is the true handshake
    assign accept_d = in_valid_i & in_ready_q;
    assign words_d  = words_q + 8'd1;
    assign xor_d    = xor_q ^ in_data_i;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            lo_q       <= '0;
            xor_q      <= '0;
            ptr_q      <= '0;
            words_q    <= '0;
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= '0;
            wr_data_q  <= '0;
            cpu_hold_q <= 1'b1;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            wr_en_q <= 1'b0;
            case (state_q)
                S_IDLE, S_DONE, S_ERR: begin
                    if (start_i) begin
                        state_q    <= S_HDR;
                        done_q     <= 1'b0;
                        err_q      <= 1'b0;
                        words_q    <= '0;
                        xor_q      <= '0;
                        ptr_q      <= '0;
                        cpu_hold_q <= 1'b1;
                        in_ready_q <= 1'b1;
                    end
                end
                S_HDR: begin
                    if (accept_d) begin
                        n_q <= in_data_i;
                        if ({1'b0, in_data_i} > DEPTH_N) begin
                            state_q    <= S_ERR;
                            err_q      <= 1'b1;
                            in_ready_q <= 1'b0;
                        end else if (in_data_i == 8'd0) begin
                            state_q <= S_CSUM;
                        end else begin
                            state_q <= S_LO;
                        end
                    end
                end
                S_LO: begin
                    if (accept_d) begin
                        lo_q    <= in_data_i;
                        xor_q   <= xor_d;
                        state_q <= S_HI;
                    end
                end
                S_HI: begin
                    if (accept_d) begin
                        xor_q      <= xor_d;
                        wr_en_q    <= 1'b1;
                        wr_addr_q  <= ptr_q;
                        wr_data_q  <= {in_data_i, lo_q};
                        in_ready_q <= 1'b0;
                        state_q    <= S_WRITE;
                    end
                end
                S_WRITE: begin
                    ptr_q      <= ptr_q + ADDR_W'(1);
                    words_q    <= words_d;
                    in_ready_q <= 1'b1;
                    state_q    <= (words_d == n_q) ? S_CSUM : S_LO;
                end
                S_CSUM: begin
                    if (accept_d) begin
                        in_ready_q <= 1'b0;
                        if (in_data_i == xor_q) begin
                            state_q    <= S_DONE;
                            done_q     <= 1'b1;
                            cpu_hold_q <= 1'b0;
                        end else begin
                            state_q <= S_ERR;
                            err_q   <= 1'b1;
                        end
                    end
                end
                default: begin
                    state_q    <= S_IDLE;
                    in_ready_q <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready_o     = in_ready_q;
    assign wr_en_o        = wr_en_q;
    assign wr_addr_o      = wr_addr_q;
    assign wr_data_o      = wr_data_q;
    assign cpu_hold_o     = cpu_hold_q;
    assign done_o         = done_q;
    assign err_o          = err_q;
    assign words_loaded_o = words_q;

endmodule
